// File: rtl/hc165_reader_pkg.sv
// Shared state encoding, defaults and sizing helper for the 74HC165 chain reader.
package hc165_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_LOW    = 3'd3,
        ST_HIGH   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam int DEF_WIDTH       = 16;
    localparam int DEF_DIV         = 1;
    localparam int DEF_AUTO_PERIOD = 0;

    // Holds a sampled-bit count up to the maximum chain length of 32.
    localparam int BIT_CNT_W = 6;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hc165_reader_tick.sv
// Free-running periodic tick generator; PERIOD=0 holds it idle with no tick.
module hc165_reader_tick
    import hc165_reader_pkg::*;
#(
    parameter int PERIOD = 0
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int            CW      = cnt_w(PERIOD);
    localparam bit            ENABLED = (PERIOD > 0);
    localparam logic [CW-1:0] LAST    = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (!ENABLED || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = ENABLED && (cnt_q == LAST);

endmodule

// File: rtl/hc165_reader.sv
// Scan controller for a chain of 74HC165 shift registers: load strobe, shift clock, serial capture.
//
//   state  | meaning
//   IDLE   | waiting for IsSta or auto tick; Pldn=1, Sftclk=0
//   LOAD   | Pldn=0 for DIV cycles, chain latches its parallel inputs
//   SETTLE | Pldn=1 for DIV cycles before the first sample
//   LOW    | Sftclk=0 for DIV cycles, SDin sampled in the last cycle
//   HIGH   | Sftclk=1 for DIV cycles, rising edge advances the chain
//   DONE   | one cycle: RdData holds the new word, IsDone=1
module hc165_reader
    import hc165_reader_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DIV         = DEF_DIV,
    parameter int AUTO_PERIOD = DEF_AUTO_PERIOD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             IsSta,
    input  logic             SDin,
    output logic             Pldn,
    output logic             Sftclk,
    output logic [WIDTH-1:0] RdData,
    output logic             IsDone,
    output logic             Changed,
    output logic             Busy
);

    localparam int                   PH_W     = cnt_w(DIV);
    localparam logic [PH_W-1:0]      PH_LAST  = PH_W'(DIV - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [PH_W-1:0]      phase_q, phase_d;
    logic [BIT_CNT_W-1:0] bit_q, bit_d;
    logic [WIDTH-1:0]     shift_q, shift_d;
    logic [WIDTH-1:0]     rdata_q, rdata_d;
    logic                 changed_q, changed_d;
    logic                 pldn_q, pldn_d;
    logic                 sftclk_q, sftclk_d;
    logic                 auto_tick;
    logic                 phase_end;

    hc165_reader_tick #(
        .PERIOD (AUTO_PERIOD)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (auto_tick)
    );

    assign phase_end = (phase_q == '0);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        rdata_d   = rdata_q;
        changed_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A tick and a request in the same cycle merge into one scan.
                if (IsSta || auto_tick) begin
                    state_d = ST_LOAD;
                    phase_d = PH_LAST;
                    bit_d   = '0;
                end
            end
            ST_LOAD: begin
                if (phase_end) begin
                    state_d = ST_SETTLE;
                    phase_d = PH_LAST;
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            ST_SETTLE: begin
                if (phase_end) begin
                    state_d = ST_LOW;
                    phase_d = PH_LAST;
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            ST_LOW: begin
                if (phase_end) begin
                    shift_d = (shift_q << 1) | WIDTH'(SDin);
                    bit_d   = bit_q + BIT_CNT_W'(1);
                    phase_d = PH_LAST;
                    // No trailing clock edge once the last bit is in.
                    if (bit_q == BIT_LAST) begin
                        state_d   = ST_DONE;
                        rdata_d   = shift_d;
                        changed_d = (shift_d != rdata_q);
                    end else begin
                        state_d = ST_HIGH;
                    end
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            ST_HIGH: begin
                if (phase_end) begin
                    state_d = ST_LOW;
                    phase_d = PH_LAST;
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        pldn_d   = (state_d != ST_LOAD);
        sftclk_d = (state_d == ST_HIGH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rdata_q   <= '0;
            changed_q <= 1'b0;
            pldn_q    <= 1'b1;
            sftclk_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            rdata_q   <= rdata_d;
            changed_q <= changed_d;
            pldn_q    <= pldn_d;
            sftclk_q  <= sftclk_d;
        end
    end

    assign Pldn    = pldn_q;
    assign Sftclk  = sftclk_q;
    assign RdData  = rdata_q;
    assign IsDone  = (state_q == ST_DONE);
    assign Changed = changed_q;
    assign Busy    = (state_q != ST_IDLE);

endmodule
